// File: rtl/msdap_pkg.sv
// Shared types, widths and sample alignment for the MSDAP filter engine.
package msdap_pkg;

   localparam int unsigned ACC_W          = 40;
   localparam int unsigned NGROUPS        = 16;
   localparam int unsigned DATA_AW        = 8;
   localparam int unsigned COEFF_AW       = 9;
   localparam int unsigned RJ_AW          = 4;
   localparam int unsigned CNT_W          = 8;
   localparam int unsigned WORD_W         = 16;
   localparam int unsigned FRAC_W         = 16;
   localparam int unsigned COEFF_SIGN_BIT = 8;
   localparam int unsigned COEFF_K_MSB    = 7;

   localparam logic [RJ_AW-1:0] LAST_J = RJ_AW'(NGROUPS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RJ    = 2'd1,
      ACC   = 2'd2,
      SHIFT = 2'd3
   } state_t;

   // Place a 16-bit sample in the integer part of the accumulator format.
   function automatic logic [ACC_W-1:0] align_sample(input logic [WORD_W-1:0] x);
      return {{(ACC_W - WORD_W - FRAC_W){x[WORD_W-1]}}, x, {FRAC_W{1'b0}}};
   endfunction

endpackage

// File: rtl/msdap_filter_engine_if.sv
// Control and memory-read bundle between the filter engine and its memories.
interface msdap_filter_engine_if;
   import msdap_pkg::*;

   logic                start;
   logic [DATA_AW-1:0]  wr_ptr;
   logic [RJ_AW-1:0]    rj_addr;
   logic [WORD_W-1:0]   rj_data;
   logic [COEFF_AW-1:0] coeff_addr;
   logic [WORD_W-1:0]   coeff_data;
   logic [DATA_AW-1:0]  data_addr;
   logic [WORD_W-1:0]   data_data;
   logic                busy;
   logic [ACC_W-1:0]    y_out;
   logic                y_valid;

   modport master (
      input  start, wr_ptr, rj_data, coeff_data, data_data,
      output rj_addr, coeff_addr, data_addr, busy, y_out, y_valid
   );

   modport slave (
      output start, wr_ptr, rj_data, coeff_data, data_data,
      input  rj_addr, coeff_addr, data_addr, busy, y_out, y_valid
   );

endinterface

// File: rtl/msdap_filter_engine.sv
// Per-channel shift-add filter: walks 16 Rj groups and produces one 40-bit result per sample.
module msdap_filter_engine
   import msdap_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   msdap_filter_engine_if.master bus
);

   state_t              state, state_n;
   logic [DATA_AW-1:0]  base, base_n;
   logic [RJ_AW-1:0]    j, j_n;
   logic [COEFF_AW-1:0] cp, cp_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [ACC_W-1:0]    u, u_n;
   logic [ACC_W-1:0]    acc, acc_n;
   logic [ACC_W-1:0]    y_out, y_out_n;
   logic                y_valid, y_valid_n;
   logic                busy, busy_n;
   logic [DATA_AW-1:0]  daddr_q, daddr_n;
   logic [DATA_AW-1:0]  tap_addr;
   logic [ACC_W-1:0]    xe;
   logic [ACC_W-1:0]    acc_sum;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base    <= '0;
         j       <= '0;
         cp      <= '0;
         cnt     <= '0;
         u       <= '0;
         acc     <= '0;
         y_out   <= '0;
         y_valid <= 1'b0;
         busy    <= 1'b0;
         daddr_q <= '0;
      end else begin
         base    <= base_n;
         j       <= j_n;
         cp      <= cp_n;
         cnt     <= cnt_n;
         u       <= u_n;
         acc     <= acc_n;
         y_out   <= y_out_n;
         y_valid <= y_valid_n;
         busy    <= busy_n;
         daddr_q <= daddr_n;
      end
   end

   // Next-state and datapath update; memory reads return in the same cycle.
   always_comb begin
      state_n   = state;
      base_n    = base;
      j_n       = j;
      cp_n      = cp;
      cnt_n     = cnt;
      u_n       = u;
      acc_n     = acc;
      y_out_n   = y_out;
      y_valid_n = 1'b0;
      busy_n    = busy;
      daddr_n   = daddr_q;
      acc_sum   = '0;
      tap_addr  = base - DATA_AW'(bus.coeff_data[COEFF_K_MSB:0]);
      xe        = align_sample(bus.data_data);

      case (state)
         IDLE: begin
            if (bus.start) begin
               base_n  = bus.wr_ptr;
               j_n     = '0;
               cp_n    = '0;
               acc_n   = '0;
               busy_n  = 1'b1;
               state_n = RJ;
            end
         end
         RJ: begin
            u_n     = '0;
            cnt_n   = bus.rj_data[CNT_W-1:0];
            state_n = (cnt_n == '0) ? SHIFT : ACC;
         end
         ACC: begin
            daddr_n = tap_addr;
            u_n     = bus.coeff_data[COEFF_SIGN_BIT] ? (u - xe) : (u + xe);
            cp_n    = COEFF_AW'(cp + 1'b1);
            cnt_n   = CNT_W'(cnt - 1'b1);
            if (cnt_n == '0) state_n = SHIFT;
         end
         SHIFT: begin
            acc_sum = acc + u;
            acc_n   = ACC_W'($signed(acc_sum) >>> 1);
            if (j == LAST_J) begin
               y_out_n   = acc_n;
               y_valid_n = 1'b1;
               busy_n    = 1'b0;
               state_n   = IDLE;
            end else begin
               j_n     = RJ_AW'(j + 1'b1);
               state_n = RJ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Tap address is live during ACC and holds its last value otherwise.
   assign bus.data_addr  = (state == ACC) ? tap_addr : daddr_q;
   assign bus.rj_addr    = j;
   assign bus.coeff_addr = cp;
   assign bus.busy       = busy;
   assign bus.y_out      = y_out;
   assign bus.y_valid    = y_valid;

   // Upper memory bits carry no meaning for the engine.
   logic unused_bits;
   assign unused_bits = ^{bus.rj_data[WORD_W-1:CNT_W], bus.coeff_data[WORD_W-1:COEFF_SIGN_BIT+1]};

endmodule

// File: doc/msdap_filter_engine.md
Name: msdap_filter_engine

Overview:
Per-channel compute engine that consumes the Rj, coefficient and data memories filled by the write side, and produces one 40-bit filtered output per input sample.
- On each new-sample `start`, walks the 16 Rj groups in order.
- Fetches each group's coefficients sequentially and gathers the delayed samples from the circular data memory.
- Forms the shift-add result y = 2^-1(...2^-1(2^-1(u1) + u2)... + u16).
- Two instances (left/right) sit between the memory blocks and the output serializer.

Parameters:
ACC_W, 40, accumulator and output width
NGROUPS, 16, number of Rj groups
DATA_AW, 8, data memory address width (256-entry circular buffer)
COEFF_AW, 9, coefficient memory address width (512 entries)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: new sample written at wr_ptr
wr_ptr  input  DATA_AW  address of newest sample x(n)
rj_addr  output  4  Rj memory address (read data combinational)
rj_data  input  16  Rj value; only [7:0] used as coefficient count
coeff_addr  output  COEFF_AW  coefficient memory address
coeff_data  input  16  coefficient: [8]=sign (1=subtract), [7:0]=delay k
data_addr  output  DATA_AW  data memory read address
data_data  input  16  sample read (two's complement)
busy  output  1  high from accepted start until y_valid
y_out  output  ACC_W  filtered output, held until next result
y_valid  output  1  one-cycle pulse, y_out updated

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - busy, y_valid, y_out, rj_addr, coeff_addr, data_addr, acc, u, group index j and coefficient pointer cp are all 0.
  - Reset mid-computation aborts with no y_valid.
- Memory reads are combinational: the address driven in a cycle is consumed the same cycle.
- States IDLE, RJ, ACC, SHIFT:
  - IDLE: on start, latch wr_ptr into base; j=0, cp=0, acc=0; go to RJ. start is ignored in every other state.
  - RJ: rj_addr=j; u=0; cnt=rj_data[7:0]. If cnt==0, go to SHIFT; else go to ACC.
  - ACC: coeff_addr=cp; data_addr=base - coeff_data[7:0] (mod 256).
    - Sample extension: xe = {8{x[15]}, x, 16'b0}.
    - u += xe if sign==0, else u -= xe.
    - cp++ (mod 512); cnt--. When cnt reaches 0 after the update, go to SHIFT.
  - SHIFT: acc = (acc + u) >>> 1 (arithmetic, ACC_W bits, wrap on overflow).
    - If j == NGROUPS-1: y_out <= new acc, y_valid <= 1 for one cycle, busy <= 0, go to IDLE.
    - Else: j++, go to RJ.
- Latency: S = sum of the 16 Rj counts. Final SHIFT edge is 32+S edges after the edge that samples start; y_valid is high in the following cycle.
- cp is not reset between groups. It is contiguous across groups and reset to 0 only at start.
- Delay k > n reads whatever the data memory holds. It is zero after the memory's clear/reset; no special handling in the engine.
- A start coincident with the y_valid cycle is accepted (state is IDLE).
- Address outputs hold their last value in IDLE.

Decomposition:
- Shared package msdap_pkg:
  - state enum (IDLE, RJ, ACC, SHIFT);
  - width constants ACC_W, DATA_AW, COEFF_AW, NGROUPS;
  - coefficient field positions COEFF_SIGN_BIT=8, COEFF_K_MSB=7.
- Single module, no sub-module. The sign-extend/align is a package function, msdap_pkg::align_sample.

Test Plan:
- All Rj=0, start → y_valid exactly 33 cycles after start, y_out=0x00_0000_0000, busy high 32 cycles.
- Rj[0]=1, others 0, coeff[0]=0x000, data[wr_ptr=0]=0x4000 → y_out=0x00_0000_4000, y_valid at cycle 34.
- Same as previous but coeff[0]=0x100 → y_out=0xFF_FFFF_C000.
- wr_ptr=2, Rj[15]=1, coeff[0]=0x005, data[253]=0x0100 → data_addr=0xFD during ACC, y_out=0x00_0080_0000.
- Rj[0]=2, Rj[1]=1 → coeff_addr sequence 0,1 (group 0) then 2 (group 1); y_valid at cycle 36.
- Second start pulse while busy → ignored (single y_valid). Assert rst_n low mid-ACC → busy=0, y_valid=0, y_out=0 immediately; next start completes normally.
